// File: rtl/wb_write_arbiter_if.sv
// Bus bundle for the writeback arbiter: pipeline port A, long-latency port B,
// the register-file write port and the status outputs seen by the hazard unit.
interface wb_write_arbiter_if #(
   parameter int N = 32
);
   logic         a_we;
   logic [4:0]   a_rd;
   logic [N-1:0] a_data;
   logic         b_valid;
   logic         b_ready;
   logic [4:0]   b_rd;
   logic [N-1:0] b_data;
   logic         RegWrite;
   logic [4:0]   WriteReg;
   logic [N-1:0] WriteData;
   logic [31:0]  pending;
   logic         idle;
   logic         waw_err;

   // Handshake: port B transfers on a posedge where b_valid && b_ready; the
   // source holds b_rd/b_data stable while b_valid is high. Port A has no
   // ready and is consumed in the cycle a_we is asserted.
   modport master (
      output a_we, a_rd, a_data, b_valid, b_rd, b_data,
      input  b_ready, RegWrite, WriteReg, WriteData, pending, idle, waw_err
   );

   modport slave (
      input  a_we, a_rd, a_data, b_valid, b_rd, b_data,
      output b_ready, RegWrite, WriteReg, WriteData, pending, idle, waw_err
   );
endinterface

// File: rtl/wb_write_arbiter.sv
// Owns the register-file write port: pipeline writeback wins every cycle, the
// long-latency results queue in a small FIFO and drain when the port is free.
module wb_write_arbiter #(
   parameter int N     = 32,
   parameter int DEPTH = 4
) (
   input logic                 clk,
   input logic                 rst,
   wb_write_arbiter_if.slave   bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [AW:0]   count;
   logic [DEPTH-1:0] live;
   logic [4:0]    rd_mem   [DEPTH];
   logic [N-1:0]  data_mem [DEPTH];
   logic          waw_q;

   logic        a_wr;
   logic        empty;
   logic        full;
   logic        pop;
   logic        push;
   logic        live_in;
   logic [31:0] pending_raw;

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(DEPTH));
   assign a_wr  = bus.a_we && (bus.a_rd != 5'd0) && !rst;
   assign pop   = !a_wr && !empty && !rst;
   assign bus.b_ready = !full && !rst;
   assign push  = bus.b_valid && bus.b_ready;
   // A same-cycle A write to the same register kills the entry on arrival.
   assign live_in = (bus.b_rd != 5'd0) && !(a_wr && (bus.b_rd == bus.a_rd));

   always_comb begin
      pending_raw = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (live[i]) pending_raw[rd_mem[i]] = 1'b1;
      end
   end

   assign bus.pending = rst ? 32'd0 : (pending_raw & ~32'd1);
   assign bus.idle    = empty || rst;
   assign bus.waw_err = waw_q;

   always_comb begin
      bus.RegWrite  = 1'b0;
      bus.WriteReg  = 5'd0;
      bus.WriteData = '0;
      if (a_wr) begin
         bus.RegWrite  = 1'b1;
         bus.WriteReg  = bus.a_rd;
         bus.WriteData = bus.a_data;
      end else if (pop) begin
         bus.RegWrite  = live[rptr];
         bus.WriteReg  = rd_mem[rptr];
         bus.WriteData = data_mem[rptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr  <= '0;
         wptr  <= '0;
         count <= '0;
         live  <= '0;
         waw_q <= 1'b0;
      end else begin
         // Pop and kill are exclusive (pop only when A is silent), and a push
         // never lands on a live slot, so the writes below never collide.
         for (int i = 0; i < DEPTH; i++) begin
            if (a_wr && (rd_mem[i] == bus.a_rd)) live[i] <= 1'b0;
         end
         if (pop) begin
            live[rptr] <= 1'b0;
            rptr       <= rptr + 1'b1;
         end
         if (push) begin
            live[wptr]     <= live_in;
            rd_mem[wptr]   <= bus.b_rd;
            data_mem[wptr] <= bus.b_data;
            wptr           <= wptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (a_wr && pending_raw[bus.a_rd]) waw_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scenarios plus a random phase, each cycle checked against a
// queue-based model of the writeback arbiter.
module tb_wb_write_arbiter;
   localparam int N     = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        live;
   } ent_t;

   logic clk;
   logic rst;
   wb_write_arbiter_if #(.N(N)) bus ();

   wb_write_arbiter #(.N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   ent_t        exp_q[$];
   logic        exp_waw = 1'b0;
   logic [31:0] dut_rf [32];

   logic        obs_we;
   logic [4:0]  obs_reg;
   logic [31:0] obs_data;
   logic        obs_ready;
   logic [31:0] obs_pend;
   logic        obs_idle;
   logic        obs_waw;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic awe, input logic [4:0] ard, input logic [31:0] adata,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bdata);
      bus.a_we    = awe;
      bus.a_rd    = ard;
      bus.a_data  = adata;
      bus.b_valid = bv;
      bus.b_rd    = brd;
      bus.b_data  = bdata;
   endtask

   // One clock: check outputs at negedge against the model, then advance the model.
   task automatic cycle();
      logic        a_wr;
      logic        e_we;
      logic [4:0]  e_reg;
      logic [31:0] e_data;
      logic        e_ready;
      logic [31:0] e_pend;
      logic        e_idle;
      ent_t        ne;
      @(negedge clk);
      a_wr   = bus.a_we && (bus.a_rd != 5'd0) && !rst;
      e_pend = '0;
      foreach (exp_q[i]) if (exp_q[i].live) e_pend[exp_q[i].rd] = 1'b1;
      e_ready = !rst && (exp_q.size() < DEPTH);
      e_idle  = rst || (exp_q.size() == 0);
      e_we = 1'b0; e_reg = '0; e_data = '0;
      if (a_wr) begin
         e_we = 1'b1; e_reg = bus.a_rd; e_data = bus.a_data;
      end else if (!rst && exp_q.size() > 0) begin
         e_we = exp_q[0].live; e_reg = exp_q[0].rd; e_data = exp_q[0].data;
      end
      obs_we    = bus.RegWrite;
      obs_reg   = bus.WriteReg;
      obs_data  = bus.WriteData;
      obs_ready = bus.b_ready;
      obs_pend  = bus.pending;
      obs_idle  = bus.idle;
      obs_waw   = bus.waw_err;
      chk("RegWrite",  obs_we,    e_we);
      chk("WriteReg",  obs_reg,   e_reg);
      chk("WriteData", obs_data,  e_data);
      chk("b_ready",   obs_ready, e_ready);
      chk("pending",   obs_pend,  rst ? 32'd0 : e_pend);
      chk("idle",      obs_idle,  e_idle);
      chk("waw_err",   obs_waw,   exp_waw);
      if (obs_we === 1'b1) dut_rf[obs_reg] = obs_data;
      if (rst) begin
         exp_q.delete();
         exp_waw = 1'b0;
      end else begin
         if (a_wr) begin
            if (e_pend[bus.a_rd]) exp_waw = 1'b1;
            foreach (exp_q[i]) if (exp_q[i].rd == bus.a_rd) exp_q[i].live = 1'b0;
         end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
         end
         if (bus.b_valid && e_ready) begin
            ne.rd   = bus.b_rd;
            ne.data = bus.b_data;
            ne.live = (bus.b_rd != 5'd0) && !(a_wr && bus.b_rd == bus.a_rd);
            exp_q.push_back(ne);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      foreach (dut_rf[i]) dut_rf[i] = '0;
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      cycle();
      chk("reset_idle", obs_idle, 1'b1);
      cycle();
      rst = 1'b0;

      // single B result drains the next cycle
      drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
      cycle();
      drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("t1_we",   obs_we, 1'b1);
      chk("t1_reg",  obs_reg, 5'd5);
      chk("t1_data", obs_data, 32'hDEADBEEF);
      chk("t1_pend5", obs_pend[5], 1'b1);
      cycle();
      chk("t1_pend_clear", obs_pend, 32'd0);
      chk("t1_idle", obs_idle, 1'b1);

      // A takes priority over a queued entry
      drive(0, 0, 0, 1, 5'd7, 32'h77);
      cycle();
      drive(1, 5'd3, 32'h11, 0, 0, 0);
      cycle();
      chk("t2_a_reg", obs_reg, 5'd3);
      drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("t2_b_reg", obs_reg, 5'd7);
      chk("t2_waw", obs_waw, 1'b0);

      // fill under continuous A traffic, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(1, 5'd20, 32'h100 + i, 1, 5'(i), 32'h1000 + i);
         cycle();
      end
      drive(1, 5'd20, 32'h200, 0, 0, 0);
      cycle();
      chk("t3_full_ready", obs_ready, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         chk("t3_drain_reg", obs_reg, 5'(i));
         chk("t3_drain_we", obs_we, 1'b1);
         if (i == 2) chk("t3_ready_back", obs_ready, 1'b1);
      end

      // WAW kill
      drive(0, 0, 0, 1, 5'd9, 32'hAAAA);
      cycle();
      drive(1, 5'd9, 32'h5555, 0, 0, 0);
      cycle();
      drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("t4_killed_we", obs_we, 1'b0);
      chk("t4_waw", obs_waw, 1'b1);
      chk("t4_r9", dut_rf[9], 32'h5555);

      // x0 entry with A targeting x0
      rst = 1'b1; cycle(); rst = 1'b0;
      drive(1, 5'd0, 32'h1234, 1, 5'd0, 32'hFFFF);
      cycle();
      chk("t5_we0", obs_we, 1'b0);
      drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("t5_we1", obs_we, 1'b0);
      chk("t5_pend", obs_pend, 32'd0);
      cycle();
      chk("t5_idle", obs_idle, 1'b1);

      // reset discards queued entries
      drive(1, 5'd30, 32'h1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         bus.b_valid = 1'b1; bus.b_rd = 5'(11 + i); bus.b_data = 32'hC0 + i;
         cycle();
      end
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1; cycle(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("t6_no_write", obs_we, 1'b0);
         chk("t6_idle", obs_idle, 1'b1);
         chk("t6_pend", obs_pend, 32'd0);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom,
               $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
         rst = ($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
